// File: rtl/op_status_ctrl.sv
// op_status_ctrl: sequencer for a single-operation datapath engine.
// Launches the engine with a one-cycle op_go pulse, watches done/fail and
// a watchdog, and keeps sticky, clearable status {done, busy, error} plus a
// maskable registered interrupt and a saturating success counter.
// Optional feature macro: OP_RETRY_EN (automatic reissue after fail/timeout,
// up to MAX_RETRY times). The default build has no retry logic.
module op_status_ctrl #(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_done,
  input  logic             op_fail,
  input  logic             clr_status,
  input  logic [2:0]       irq_mask,
  output logic             op_go,
  output logic [2:0]       status,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] op_count,
  output logic             irq
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_FAIL  = 3'd4;

  // Last watchdog value in RUN; reaching it means TIMEOUT RUN cycles elapsed.
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [1:0]       err_nxt;
  logic [2:0]       status_nxt;
  logic [CNT_W-1:0] wd_cnt;
  logic             wd_expired;
  logic             retry_ok;

  assign wd_expired = (wd_cnt == WD_LAST);

`ifdef OP_RETRY_EN
  localparam int unsigned RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  logic [RTY_W-1:0] retry_cnt;

  assign retry_ok = (retry_cnt < RTY_W'(MAX_RETRY));

  // Retry counter: cleared whenever heading to IDLE, bumped on each reissue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_cnt <= '0;
    end else if (state_nxt == S_IDLE) begin
      retry_cnt <= '0;
    end else if ((state == S_RUN) && (state_nxt == S_ISSUE)) begin
      retry_cnt <= retry_cnt + RTY_W'(1);
    end
  end
`else
  // Without retries every fail/timeout ends the operation.
  logic unused_retry_cfg;
  assign unused_retry_cfg = (MAX_RETRY != 0);
  assign retry_ok = 1'b0;
`endif

  // Next-state and next error-code decode; fail outranks done outranks timeout.
  always_comb begin
    state_nxt = state;
    err_nxt   = err_code;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (op_fail) begin
          if (retry_ok) begin
            state_nxt = S_ISSUE;
          end else begin
            state_nxt = S_FAIL;
            err_nxt   = 2'b01;
          end
        end else if (op_done) begin
          state_nxt = S_DONE;
        end else if (wd_expired) begin
          if (retry_ok) begin
            state_nxt = S_ISSUE;
          end else begin
            state_nxt = S_FAIL;
            err_nxt   = 2'b10;
          end
        end
      end
      S_DONE, S_FAIL: begin
        // A clear wins over a simultaneous start; IDLE ignores nothing yet.
        if (clr_status) begin
          state_nxt = S_IDLE;
          err_nxt   = 2'b00;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        err_nxt   = 2'b00;
      end
    endcase
  end

  // Status word as it will be after this edge: {done, busy, error}.
  assign status_nxt = {(state_nxt == S_DONE),
                       (state_nxt == S_ISSUE) || (state_nxt == S_RUN),
                       (state_nxt == S_FAIL)};

  // State and registered outputs, all derived from the next state so that
  // status and irq rise in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      op_go    <= 1'b0;
      status   <= 3'b000;
      err_code <= 2'b00;
      irq      <= 1'b0;
    end else begin
      state    <= state_nxt;
      op_go    <= (state_nxt == S_ISSUE);
      status   <= status_nxt;
      err_code <= err_nxt;
      irq      <= |(status_nxt & ~irq_mask);
    end
  end

  // Successful-operation counter, bumped on DONE entry, sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= '0;
    end else if ((state != S_DONE) && (state_nxt == S_DONE) && (op_count != '1)) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

  // Watchdog: zeroed during ISSUE, counts every RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state == S_ISSUE) begin
      wd_cnt <= '0;
    end else if (state == S_RUN) begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_op_status_ctrl.sv
// Scoreboard bench for op_status_ctrl: the driver issues randomized
// operations and pushes the expected outcome; a monitor pops and compares
// whenever the DUT presents a done/error outcome.
module tb_op_status_ctrl;

  localparam int TO    = 8;
  localparam int CW    = 4;
  localparam int MAX_R = 2;
`ifdef OP_RETRY_EN
  localparam int RETRIES = MAX_R;
`else
  localparam int RETRIES = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start, op_done, op_fail, clr_status;
  logic [2:0]    irq_mask;
  logic          op_go;
  logic [2:0]    status;
  logic [1:0]    err_code;
  logic [CW-1:0] op_count;
  logic          irq;

  op_status_ctrl #(.TIMEOUT(TO), .CNT_W(CW), .MAX_RETRY(MAX_R)) dut (
    .clk(clk), .rst(rst), .start(start), .op_done(op_done), .op_fail(op_fail),
    .clr_status(clr_status), .irq_mask(irq_mask), .op_go(op_go),
    .status(status), .err_code(err_code), .op_count(op_count), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic [1:0] err;
    int         cnt;
    int         go;
    int         lat;
    logic       irq;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   exp_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor / scoreboard checker
  int   go_cnt = 0;
  int   lat = 0;
  bit   inflight = 0;
  bit   busy_bad = 0;
  bit   prev_out = 0;
  always @(negedge clk) begin
    bit   out_now;
    exp_t e;
    if (rst) begin
      go_cnt = 0; lat = 0; inflight = 0; busy_bad = 0; prev_out = 0;
    end else begin
      if (op_go) begin go_cnt++; lat = 0; inflight = 1; end
      else lat++;
      out_now = status[0] | status[2];
      if (out_now && !prev_out) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_outcome", 32'(status), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("status", 32'(status), 32'(e.st));
          chk("err_code", 32'(err_code), 32'(e.err));
          chk("op_count", 32'(op_count), 32'(e.cnt));
          chk("op_go_pulses", 32'(go_cnt), 32'(e.go));
          chk("latency", 32'(lat), 32'(e.lat));
          chk("irq", 32'(irq), 32'(e.irq));
          chk("busy_during_op", 32'(busy_bad), 32'd0);
        end
        go_cnt = 0; inflight = 0; busy_bad = 0;
      end else if (inflight && !out_now) begin
        if (status !== 3'b010 || irq !== ~irq_mask[1]) busy_bad = 1;
      end
      prev_out = out_now;
    end
  end

  // kind: 0 done, 1 fail, 2 done+fail together, 3 no response (timeout)
  task automatic run_op(input int kind, input int d, input logic [2:0] mask);
    exp_t e;
    int   guard;
    bit   fails;
    fails = (kind != 0);
    if (!fails && exp_count < (1 << CW) - 1) exp_count++;
    e.st  = fails ? 3'b001 : 3'b100;
    e.err = (kind == 3) ? 2'b10 : (fails ? 2'b01 : 2'b00);
    e.cnt = exp_count;
    e.go  = fails ? 1 + RETRIES : 1;
    e.lat = ((kind == 3) ? TO : d) + 1;
    e.irq = |(e.st & ~mask);
    exp_q.push_back(e);

    irq_mask = mask;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int a = 0; a < e.go; a++) begin
      guard = 0;
      while (!op_go && guard < 40) begin @(negedge clk); guard++; end
      if (!op_go) begin chk("op_go_wait", 32'd0, 32'd1); break; end
      if (kind == 3) begin
        @(negedge clk);
      end else begin
        repeat (d) begin @(negedge clk); start = 1'($urandom % 2); end
        start   = 1'b0;
        op_done = (kind != 1);
        op_fail = (kind != 0);
        @(negedge clk);
        op_done = 1'b0;
        op_fail = 1'b0;
      end
    end
    guard = 0;
    while (!(status[0] | status[2]) && guard < 40) begin @(negedge clk); guard++; end
    if (!(status[0] | status[2])) chk("outcome_wait", 32'd0, 32'd1);
    // Hold in DONE/FAIL with ignored start and engine noise
    repeat ($urandom_range(0, 3)) begin
      start   = 1'($urandom % 2);
      op_done = 1'($urandom % 2);
      op_fail = 1'($urandom % 2);
      @(negedge clk);
    end
    clr_status = 1'b1;
    start      = 1'($urandom % 2);
    op_done    = 1'b0;
    op_fail    = 1'b0;
    @(negedge clk);
    clr_status = 1'b0;
    start      = 1'b0;
    chk("status_after_clr", 32'(status), 32'd0);
    chk("err_after_clr", 32'(err_code), 32'd0);
    chk("irq_after_clr", 32'(irq), 32'd0);
    chk("count_after_clr", 32'(op_count), 32'(exp_count));
    // IDLE with stray engine pulses
    repeat ($urandom_range(0, 2)) begin
      op_done = 1'($urandom % 2);
      op_fail = 1'($urandom % 2);
      @(negedge clk);
    end
    op_done = 1'b0;
    op_fail = 1'b0;
  endtask

  task automatic rand_op();
    run_op(int'($urandom % 4), int'($urandom_range(1, TO)), 3'($urandom % 8));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op_done = 1'b0; op_fail = 1'b0;
    clr_status = 1'b0; irq_mask = 3'b000;
    repeat (3) @(negedge clk);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_op_go", 32'(op_go), 32'd0);
    chk("rst_err", 32'(err_code), 32'd0);
    chk("rst_count", 32'(op_count), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_status", 32'(status), 32'd0);

    run_op(0, 3, 3'b000);
    run_op(3, 0, 3'b000);
    run_op(2, 2, 3'b000);
    run_op(0, TO, 3'b010);
    run_op(1, 1, 3'b111);
    run_op(0, 1, 3'b101);
    run_op(1, TO, 3'b000);
    run_op(3, 0, 3'b001);
    repeat (20) rand_op();

    // Reset in the middle of RUN, then a late engine response
    irq_mask = 3'b000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_status", 32'(status), 32'd0);
    chk("midrst_op_go", 32'(op_go), 32'd0);
    chk("midrst_count", 32'(op_count), 32'd0);
    chk("midrst_irq", 32'(irq), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    op_done = 1'b1;
    @(negedge clk);
    op_done = 1'b0;
    exp_count = 0;
    repeat (3) @(negedge clk);
    chk("postrst_status", 32'(status), 32'd0);
    chk("postrst_op_go", 32'(op_go), 32'd0);
    chk("postrst_err", 32'(err_code), 32'd0);
    chk("postrst_count", 32'(op_count), 32'd0);

    // Drive the success counter into saturation
    repeat ((1 << CW) + 2) run_op(0, int'($urandom_range(1, TO)), 3'($urandom % 8));
    repeat (6) rand_op();

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Absolute time bound
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
